execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of the 5-stage RV32 pipeline. Sits between the ID/EX register and memoryStage.
//  Forwards operands, runs ALU ops in 1 cycle and MUL iteratively over several cycles,
//  resolves BEQ/JAL, and owns the EX/MEM register driving memoryStage's *M inputs.
//  Stalls upstream (StallE) while a multiply is in flight.
// PARAMETERS
//  MUL_CYCLES  4  multiply iterations; one of 1,2,4,8,16,32; 32/MUL_CYCLES bits per iteration
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset; asynchronous, active-high
//  RD1E,RD2E    in   32  register-file operands from ID/EX
//  ImmExtE      in   32  sign-extended immediate
//  PCE,PCPlus4E in   32  instruction PC, PC+4
//  RdE          in   5   destination register
//  RegWriteE,MemWriteE,ALUSrcE,BranchE,JumpE in 1 decoded control
//  ResultSrcE   in   2   result-select control, passed through
//  ALUControlE  in   4   ALU op (encoding below)
//  ForwardAE,ForwardBE in 2  00 regfile, 01 ResultW, 10 ALUResultM
//  ResultW      in   32  writeback-stage result for forwarding
//  ALUResultM,WriteDataM,PCPlus4M out 32  EX/MEM register to memoryStage
//  RdM          out  5   EX/MEM destination register
//  RegWriteM,MemWriteM out 1  EX/MEM control
//  ResultSrcM   out  2   EX/MEM result select
//  PCSrcE       out  1   redirect fetch (combinational)
//  PCTargetE    out  32  PCE + ImmExtE (combinational)
//  StallE       out  1   hold IF/ID/EX inputs stable (combinational)
// BEHAVIOUR
//  - Reset: all EX/MEM outputs 0, FSM IDLE, counter and product 0. Reset mid-multiply aborts; nothing written.
//  - SrcA = fwd(ForwardAE); WriteData = fwd(ForwardBE); SrcB = ALUSrcE ? ImmExtE : WriteData. Fwd code 11 = regfile.
//  - ALU ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed, 1/0),
//    0110 SLL, 0111 SRL, 1000 SRA (shamt = SrcB[4:0]), 1001 MUL (low 32 bits), others -> 0.
//    All arithmetic mod 2^32; no overflow flags.
//  - ZeroE = (ALU result == 0). PCSrcE = JumpE | (BranchE & ZeroE), forced 0 when state != IDLE.
//  - Non-MUL: 1-cycle latency; EX/MEM loads ALU result, WriteData, PCPlus4E, RdE and control on the next edge.
//  - MUL FSM: IDLE -> BUSY -> DONE -> IDLE.
//    IDLE with MUL: StallE=1; latch SrcA/SrcB into multiplicand/multiplier; clear product; cnt=0; go BUSY.
//    BUSY: StallE=1; add 32/MUL_CYCLES partial products per cycle; cnt++;
//      go DONE when cnt == MUL_CYCLES-1.
//    DONE: StallE=0; ALUResult = product; EX/MEM captures it with the held ID/EX fields; go IDLE.
//  - MUL occupies EX for MUL_CYCLES+1 cycles.
//  - Every edge with StallE=1 loads a bubble into EX/MEM: RegWriteM=0, MemWriteM=0, RdM=0, data 0.
//    Older instructions in MEM/WB drain normally.
//  - Operands are latched on MUL entry. Forwarding changes while BUSY are ignored.
//  - Back-to-back MULs: the second enters IDLE only after DONE and starts a fresh FSM pass.
//  - Upstream holds every E input stable while StallE=1; the block does not check this.
// STRUCTURE
//  - Shared `constants.v`: ALU op codes, FWD_* codes, existing `WORD_SIZE.
//  - One sub-module, `iterative_multiplier`: start, operands, busy, done, product32; owns the FSM and counter.
//  - ALU, forwarding muxes and the EX/MEM register stay in execute_stage.
// TESTING
//  1. ADD: SrcA=5, SrcB=7, Rd=3, RegWrite=1 -> next edge ALUResultM=12, RdM=3, RegWriteM=1, StallE=0.
//  2. Forwarding: ForwardAE=10, ALUResultM=12, ForwardBE=01, ResultW=3, SUB -> ALUResultM=9.
//  3. BEQ: equal operands, BranchE=1, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120.
//     Unequal operands -> PCSrcE=0.
//  4. MUL, MUL_CYCLES=4: 0x0001_0003 * 0x0000_0005 -> StallE=1 for 4 cycles with bubbles;
//     cycle 5 ALUResultM=0x0005_000F. Also 0xFFFF_FFFF*2 -> 0xFFFF_FFFE.
//  5. rst pulsed during BUSY of MUL -> all outputs 0 at once; next ADD completes normally.
//  6. MUL, BEQ taken, MUL back-to-back with MUL_CYCLES=1 and 32 -> latency 2/33 cycles,
//     PCSrcE=0 while busy, both products correct.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared types and helpers for the RV32 execute stage: ALU/forwarding codes,
// multiplier FSM states, the EX/MEM payload and the single-cycle ALU.
package execute_stage_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned REG_W     = 5;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLT = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1000,
    ALU_MUL = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    word_t            alu_result;
    word_t            write_data;
    word_t            pc_plus4;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_write;
    logic [1:0]       result_src;
  } ex_mem_t;

  // Single-cycle ops; MUL and unused codes yield 0 (MUL is sourced from the multiplier).
  function automatic word_t alu_compute(input logic [3:0] op, input word_t a, input word_t b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return word_t'($signed(a) < $signed(b));
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return word_t'($signed(a) >>> b[4:0]);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, plus the fetch
// redirect and stall signals it returns upstream.
interface execute_stage_if;
  import execute_stage_pkg::*;

  word_t            RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [REG_W-1:0] RdE;
  logic             RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]       ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]       ALUControlE;

  word_t            ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
  logic [REG_W-1:0] RdM;
  logic             RegWriteM, MemWriteM, PCSrcE, StallE;
  logic [1:0]       ResultSrcM;

  modport master (
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW, RdE,
           RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
           ResultSrcE, ForwardAE, ForwardBE, ALUControlE,
    input  ALUResultM, WriteDataM, PCPlus4M, PCTargetE, RdM,
           RegWriteM, MemWriteM, PCSrcE, StallE, ResultSrcM
  );

  modport slave (
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW, RdE,
           RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
           ResultSrcE, ForwardAE, ForwardBE, ALUControlE,
    output ALUResultM, WriteDataM, PCPlus4M, PCTargetE, RdM,
           RegWriteM, MemWriteM, PCSrcE, StallE, ResultSrcM
  );

endinterface

// File: rtl/execute_stage_iterative_multiplier.sv
// Shift-add multiplier producing the low 32 bits of a*b, WORD_SIZE/MUL_CYCLES
// multiplier bits per cycle; the entry cycle already consumes the first slice.
module execute_stage_iterative_multiplier
  import execute_stage_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  word_t a,
  input  word_t b,
  output logic  busy,
  output logic  done,
  output word_t product
);

  localparam int unsigned STEP  = WORD_SIZE / MUL_CYCLES;
  localparam int unsigned CNT_W = 6;

  mul_state_e       state;
  word_t            mcand, mplier;
  logic [CNT_W-1:0] cnt;
  word_t            op_a, op_b, partial, bits, addend;
  logic [CNT_W-1:0] cnt_inc;

  // Sum of the next STEP partial products; operands come straight from the inputs on entry.
  always_comb begin
    op_a    = (state == MUL_IDLE) ? a : mcand;
    op_b    = (state == MUL_IDLE) ? b : mplier;
    partial = '0;
    bits    = op_b;
    addend  = op_a;
    for (int unsigned j = 0; j < STEP; j++) begin
      if (bits[0]) partial = partial + addend;
      bits   = bits >> 1;
      addend = addend << 1;
    end
    cnt_inc = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MUL_IDLE;
      cnt     <= '0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            product <= partial;
            mcand   <= op_a << STEP;
            mplier  <= op_b >> STEP;
            cnt     <= '0;
            if (MUL_CYCLES == 1) begin
              state <= MUL_DONE;
              done  <= 1'b1;
            end else begin
              state <= MUL_BUSY;
              busy  <= 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          product <= product + partial;
          mcand   <= op_a << STEP;
          mplier  <= op_b >> STEP;
          cnt     <= cnt_inc;
          if (cnt_inc == CNT_W'(MUL_CYCLES - 1)) begin
            state <= MUL_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        MUL_DONE: begin
          state <= MUL_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= MUL_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/execute_stage.sv
// RV32 EX stage: operand forwarding, single-cycle ALU, iterative MUL with
// upstream stall, BEQ/JAL resolution and the EX/MEM pipeline register.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  execute_stage_if.slave   bus
);

  word_t   src_a, src_b, write_data, alu_result, product;
  logic    is_mul, mul_busy, mul_done, idle, stall, zero;
  ex_mem_t ex_mem;

  always_comb begin
    case (bus.ForwardAE)
      FWD_WB:  src_a = bus.ResultW;
      FWD_MEM: src_a = ex_mem.alu_result;
      default: src_a = bus.RD1E;
    endcase
    case (bus.ForwardBE)
      FWD_WB:  write_data = bus.ResultW;
      FWD_MEM: write_data = ex_mem.alu_result;
      default: write_data = bus.RD2E;
    endcase
    src_b = bus.ALUSrcE ? bus.ImmExtE : write_data;
  end

  execute_stage_iterative_multiplier #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (is_mul),
    .a      (src_a),
    .b      (src_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(product)
  );

  // Redirects are suppressed while the multiplier owns the stage.
  always_comb begin
    is_mul     = (bus.ALUControlE == ALU_MUL);
    idle       = ~(mul_busy | mul_done);
    stall      = (is_mul & idle) | mul_busy;
    alu_result = mul_done ? product : alu_compute(bus.ALUControlE, src_a, src_b);
    zero       = (alu_result == '0);
  end

  assign bus.PCSrcE    = idle & (bus.JumpE | (bus.BranchE & zero));
  assign bus.PCTargetE = bus.PCE + bus.ImmExtE;
  assign bus.StallE    = stall;

  // Stalled edges insert a bubble so MEM/WB drain without side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem <= '0;
    end else if (stall) begin
      ex_mem <= '0;
    end else begin
      ex_mem.alu_result <= alu_result;
      ex_mem.write_data <= write_data;
      ex_mem.pc_plus4   <= bus.PCPlus4E;
      ex_mem.rd         <= bus.RdE;
      ex_mem.reg_write  <= bus.RegWriteE;
      ex_mem.mem_write  <= bus.MemWriteE;
      ex_mem.result_src <= bus.ResultSrcE;
    end
  end

  assign bus.ALUResultM = ex_mem.alu_result;
  assign bus.WriteDataM = ex_mem.write_data;
  assign bus.PCPlus4M   = ex_mem.pc_plus4;
  assign bus.RdM        = ex_mem.rd;
  assign bus.RegWriteM  = ex_mem.reg_write;
  assign bus.MemWriteM  = ex_mem.mem_write;
  assign bus.ResultSrcM = ex_mem.result_src;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: three instances (MUL_CYCLES 4, 1, 32) share one
// stimulus; a vector table plus hand-written reset and back-to-back MUL sequences.
module tb_execute_stage;
  import execute_stage_pkg::*;

  localparam int NDUT     = 3;
  localparam int MAX_WAIT = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  word_t      rd1, rd2, imm, pc, resw;
  logic [4:0] rd;
  logic       rw, mw, alusrc, br, jmp;
  logic [1:0] rsrc, fa, fb;
  logic [3:0] aluc;

  word_t      alu_m [NDUT];
  word_t      wd_m  [NDUT];
  word_t      pcp4_m[NDUT];
  word_t      tgt   [NDUT];
  logic [4:0] rd_m  [NDUT];
  logic       rw_m  [NDUT];
  logic       mw_m  [NDUT];
  logic       pcsrc [NDUT];
  logic       stall [NDUT];
  logic [1:0] rsrc_m[NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned MC = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
    execute_stage_if ifc ();
    execute_stage #(.MUL_CYCLES(MC)) dut (.clk(clk), .rst(rst), .bus(ifc));
    assign ifc.RD1E = rd1;         assign ifc.RD2E = rd2;
    assign ifc.ImmExtE = imm;      assign ifc.PCE = pc;
    assign ifc.PCPlus4E = pc + 32'd4;
    assign ifc.ResultW = resw;     assign ifc.RdE = rd;
    assign ifc.RegWriteE = rw;     assign ifc.MemWriteE = mw;
    assign ifc.ALUSrcE = alusrc;   assign ifc.BranchE = br;
    assign ifc.JumpE = jmp;        assign ifc.ResultSrcE = rsrc;
    assign ifc.ForwardAE = fa;     assign ifc.ForwardBE = fb;
    assign ifc.ALUControlE = aluc;
    assign alu_m[g] = ifc.ALUResultM;  assign wd_m[g] = ifc.WriteDataM;
    assign pcp4_m[g] = ifc.PCPlus4M;   assign tgt[g] = ifc.PCTargetE;
    assign rd_m[g] = ifc.RdM;          assign rw_m[g] = ifc.RegWriteM;
    assign mw_m[g] = ifc.MemWriteM;    assign pcsrc[g] = ifc.PCSrcE;
    assign stall[g] = ifc.StallE;      assign rsrc_m[g] = ifc.ResultSrcM;
  end

  typedef struct {
    word_t rd1, rd2, imm, pc, resw;
    logic [4:0] rd;
    logic rw, mw, alusrc, br, jmp;
    logic [1:0] rsrc, fa, fb;
    logic [3:0] aluc;
    word_t exp_alu, exp_wd;
    logic exp_pcsrc;
  } vec_t;

  typedef struct {
    word_t alu, wd, pcp4;
    logic [4:0] rd;
    logic rw, mw;
    logic [1:0] rsrc;
  } exm_t;

  exm_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   sel = 0;

  function automatic int mcyc(input int d);
    case (d)
      0: return 4;
      1: return 1;
      default: return 32;
    endcase
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input word_t a, input word_t b,
                              input word_t im, input logic src, input logic [1:0] f_a,
                              input logic [1:0] f_b, input word_t rw_val,
                              input word_t ea, input word_t ew);
    vec_t v;
    v.aluc = op; v.rd1 = a; v.rd2 = b; v.imm = im; v.alusrc = src;
    v.fa = f_a; v.fb = f_b; v.resw = rw_val; v.exp_alu = ea; v.exp_wd = ew;
    v.pc = 32'h40; v.rd = 5'd5; v.rw = 1'b1; v.mw = 1'b0; v.br = 1'b0;
    v.jmp = 1'b0; v.rsrc = 2'b00; v.exp_pcsrc = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (dut %0d, t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rd1 = v.rd1; rd2 = v.rd2; imm = v.imm; pc = v.pc; resw = v.resw; rd = v.rd;
    rw = v.rw; mw = v.mw; alusrc = v.alusrc; br = v.br; jmp = v.jmp;
    rsrc = v.rsrc; fa = v.fa; fb = v.fb; aluc = v.aluc;
  endtask

  // Drive one instruction, push its EX/MEM image, ride out any stall, then pop and compare.
  task automatic issue(input vec_t v, input string name);
    exm_t e, got;
    int   stalls, exp_st;
    logic s;
    @(negedge clk);
    drive(v);
    e.alu = v.exp_alu; e.wd = v.exp_wd; e.pcp4 = v.pc + 32'd4;
    e.rd = v.rd; e.rw = v.rw; e.mw = v.mw; e.rsrc = v.rsrc;
    sb.push_back(e);
    exp_st = (v.aluc == ALU_MUL) ? mcyc(sel) : 0;
    #1;
    check({name, " pcsrc"}, 32'(pcsrc[sel]), 32'(v.exp_pcsrc));
    check({name, " target"}, tgt[sel], v.pc + v.imm);
    stalls = 0;
    forever begin
      s = stall[sel];
      if (stalls > 0) check({name, " pcsrc busy"}, 32'(pcsrc[sel]), 32'd0);
      @(posedge clk);
      #1;
      if (!s) break;
      stalls++;
      check({name, " bubble"}, alu_m[sel] | wd_m[sel] | 32'(rd_m[sel]) |
            32'(rw_m[sel]) | 32'(mw_m[sel]), 32'd0);
      if (stalls > MAX_WAIT) begin
        check({name, " stall timeout"}, 32'(stalls), 32'(exp_st));
        break;
      end
    end
    check({name, " stall cycles"}, 32'(stalls), 32'(exp_st));
    if (sb.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check({name, " alu"}, alu_m[sel], got.alu);
      check({name, " wd"}, wd_m[sel], got.wd);
      check({name, " pcp4"}, pcp4_m[sel], got.pcp4);
      check({name, " rd"}, 32'(rd_m[sel]), 32'(got.rd));
      check({name, " regwrite"}, 32'(rw_m[sel]), 32'(got.rw));
      check({name, " memwrite"}, 32'(mw_m[sel]), 32'(got.mw));
      check({name, " resultsrc"}, 32'(rsrc_m[sel]), 32'(got.rsrc));
    end
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    sel = d;
    rst = 1'b1;
    drive(mk(ALU_ADD, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, m, a;
    rst = 1'b1;
    drive(mk(ALU_ADD, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    repeat (2) @(negedge clk);
    check("reset alu", alu_m[0], 32'd0);
    check("reset ctrl", 32'(rw_m[0]) | 32'(mw_m[0]) | 32'(rd_m[0]), 32'd0);
    check("reset stall", 32'(stall[0]), 32'd0);
    rst = 1'b0;

    v = mk(ALU_ADD, 5, 7, 0, 0, 2'b00, 2'b00, 0, 12, 7); v.rd = 5'd3; tbl.push_back(v);
    tbl.push_back(mk(ALU_SUB, 32'hAAAA, 32'hBBBB, 0, 0, 2'b10, 2'b01, 3, 9, 3));
    v = mk(ALU_SUB, 32'h55, 32'h55, 32'h20, 0, 2'b00, 2'b00, 0, 0, 32'h55);
    v.br = 1; v.pc = 32'h100; v.rw = 0; v.exp_pcsrc = 1; tbl.push_back(v);
    v = mk(ALU_SUB, 32'h55, 32'h56, 32'h20, 0, 2'b00, 2'b00, 0, 32'hFFFF_FFFF, 32'h56);
    v.br = 1; v.pc = 32'h100; v.rw = 0; tbl.push_back(v);
    tbl.push_back(mk(ALU_AND, 32'hF0F0, 32'h1234, 32'h0FF0, 1, 2'b00, 2'b00, 0, 32'h00F0, 32'h1234));
    tbl.push_back(mk(ALU_OR, 32'hF000_0000, 32'hF, 0, 0, 2'b00, 2'b00, 0, 32'hF000_000F, 32'hF));
    tbl.push_back(mk(ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, 2'b00, 2'b00, 0, 32'hF0F0_0F0F, 32'h0F0F_0F0F));
    tbl.push_back(mk(ALU_SLT, 32'hFFFF_FFFF, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1));
    tbl.push_back(mk(ALU_SLT, 1, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 0, 0, 32'hFFFF_FFFF));
    tbl.push_back(mk(ALU_SLL, 1, 32'h3F, 0, 0, 2'b00, 2'b00, 0, 32'h8000_0000, 32'h3F));
    tbl.push_back(mk(ALU_SRL, 32'h8000_0000, 4, 0, 0, 2'b00, 2'b00, 0, 32'h0800_0000, 4));
    tbl.push_back(mk(ALU_SRA, 32'h8000_0000, 4, 0, 0, 2'b00, 2'b00, 0, 32'hF800_0000, 4));
    tbl.push_back(mk(4'hF, 5, 7, 0, 0, 2'b00, 2'b00, 0, 0, 7));
    tbl.push_back(mk(ALU_ADD, 32'hFFFF_FFFF, 1, 0, 0, 2'b00, 2'b00, 0, 0, 1));
    v = mk(ALU_ADD, 0, 0, 32'hFFFF_FFF0, 0, 2'b00, 2'b00, 0, 0, 0);
    v.jmp = 1; v.pc = 32'h200; v.rd = 5'd1; v.exp_pcsrc = 1; tbl.push_back(v);
    tbl.push_back(mk(ALU_MUL, 32'h0001_0003, 5, 0, 0, 2'b00, 2'b00, 0, 32'h0005_000F, 5));
    tbl.push_back(mk(ALU_MUL, 32'hFFFF_FFFF, 2, 0, 0, 2'b00, 2'b00, 0, 32'hFFFF_FFFE, 2));
    tbl.push_back(mk(ALU_ADD, 32'h777, 3, 0, 0, 2'b10, 2'b00, 0, 1, 3));
    tbl.push_back(mk(ALU_ADD, 1, 2, 0, 0, 2'b11, 2'b11, 32'h99, 3, 2));
    v = mk(ALU_ADD, 32'h1000, 32'hDEAD_BEEF, 8, 1, 2'b00, 2'b00, 0, 32'h1008, 32'hDEAD_BEEF);
    v.mw = 1; v.rw = 0; v.rsrc = 2'b01; tbl.push_back(v);
    v = mk(ALU_ADD, 32'h100, 32'h23, 0, 0, 2'b00, 2'b00, 0, 32'h123, 32'h23);
    v.rd = 5'd9; v.rsrc = 2'b10; tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) issue(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset wipes a live EX/MEM entry immediately.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst alu", alu_m[0], 32'd0);
    check("async rst ctrl", 32'(rw_m[0]) | 32'(rd_m[0]) | pcp4_m[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during BUSY aborts the multiply; the following ADD is clean.
    m = mk(ALU_MUL, 3, 4, 0, 0, 2'b00, 2'b00, 0, 12, 4);
    a = mk(ALU_ADD, 4, 6, 0, 0, 2'b00, 2'b00, 0, 10, 6); a.rd = 5'd7;
    @(negedge clk);
    drive(m);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mul busy stall", 32'(stall[0]), 32'd1);
    #2 rst = 1'b1;
    drive(a);
    #1;
    check("rst busy stall", 32'(stall[0]), 32'd0);
    check("rst busy out", alu_m[0] | 32'(rw_m[0]) | 32'(rd_m[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    issue(a, "add after rst");
    issue(a, "add again");

    // Back-to-back MULs around a taken branch at the extreme iteration counts.
    for (int d = 1; d < NDUT; d++) begin
      do_reset(d);
      v = mk(ALU_MUL, 12345, 6789, 0, 0, 2'b00, 2'b00, 0, 32'd83810205, 6789);
      v.jmp = 1; v.rd = 5'd10; v.exp_pcsrc = 1; issue(v, "b2b mul0");
      v = mk(ALU_SUB, 7, 7, 32'h40, 0, 2'b00, 2'b00, 0, 0, 7);
      v.br = 1; v.pc = 32'h300; v.rw = 0; v.exp_pcsrc = 1; issue(v, "b2b beq");
      issue(mk(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2'b00, 2'b00, 0, 1, 32'hFFFF_FFFF), "b2b mul1");
      issue(mk(ALU_MUL, 32'h8000_0000, 3, 0, 0, 2'b00, 2'b00, 0, 32'h8000_0000, 3), "b2b mul2");
      issue(mk(ALU_MUL, 32'h1_0000, 32'h1_0000, 0, 0, 2'b00, 2'b00, 0, 0, 32'h1_0000), "b2b mul3");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
